// File: rtl/serial_paralelo_n.sv
// Serial-to-parallel receiver with comma alignment: hunts for COMMA on every bit, confirms
// LOCK_COUNT aligned commas, then delivers non-comma words on word boundaries.
module serial_paralelo_n #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] COMMA        = WIDTH'(8'hBC),
  parameter int               LOCK_COUNT   = 4,
  parameter int               MISALIGN_MAX = 2
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data2send,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic [1:0]       lock_state
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int BCW = $clog2(WIDTH);
  localparam int CCW = $clog2(LOCK_COUNT + 1);
  localparam int MCW = $clog2(MISALIGN_MAX + 1);

  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [CCW-1:0] CC_SAT   = '1;
  localparam logic [MCW-1:0] MC_SAT   = '1;

  logic [WIDTH-1:0] shift;
  logic [BCW-1:0]   bit_cnt;
  logic [CCW-1:0]   comma_cnt;
  logic [MCW-1:0]   misalign_cnt;

  logic [WIDTH-1:0] w;
  logic             is_comma;
  logic             boundary;
  logic [CCW-1:0]   comma_inc;
  logic [MCW-1:0]   mis_inc;

  assign w         = {shift[WIDTH-2:0], data_in};
  assign is_comma  = (w == COMMA);
  assign boundary  = (bit_cnt == LAST_BIT);
  assign comma_inc = (comma_cnt == CC_SAT) ? comma_cnt : comma_cnt + 1'b1;
  assign mis_inc   = (misalign_cnt == MC_SAT) ? misalign_cnt : misalign_cnt + 1'b1;

  // valid_out is a one-cycle strobe with no back-pressure: the word is presented in the
  // same cycle valid_out is high and is never held for a consumer.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      shift        <= '0;
      bit_cnt      <= '0;
      comma_cnt    <= '0;
      misalign_cnt <= '0;
      data2send    <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      active       <= 1'b0;
      lock_state   <= HUNT;
    end else begin
      shift     <= w;
      valid_out <= 1'b0;
      if (lock_state == HUNT) begin
        if (is_comma) begin
          data2send    <= COMMA;
          bit_cnt      <= '0;
          comma_cnt    <= CCW'(1);
          misalign_cnt <= '0;
          lock_state   <= SYNC;
        end
      end else begin
        bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
        if (boundary) begin
          data2send <= w;
          if (lock_state == SYNC) begin
            if (is_comma) begin
              comma_cnt <= comma_inc;
              if (comma_inc >= CCW'(LOCK_COUNT)) begin
                lock_state   <= LOCKED;
                active       <= 1'b1;
                misalign_cnt <= '0;
              end
            end else begin
              comma_cnt  <= '0;
              lock_state <= HUNT;
            end
          end else if (is_comma) begin
            misalign_cnt <= '0;
          end else begin
            data_out  <= w;
            valid_out <= 1'b1;
          end
        end else if (lock_state == LOCKED && is_comma) begin
          // A comma off the boundary means the word phase slipped.
          misalign_cnt <= mis_inc;
          if (mis_inc >= MCW'(MISALIGN_MAX)) begin
            lock_state   <= HUNT;
            active       <= 1'b0;
            comma_cnt    <= '0;
            misalign_cnt <= '0;
            bit_cnt      <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_paralelo_n.sv
// Directed bench for serial_paralelo_n: acquisition, data delivery, SYNC abort, phase slip,
// mid-word reset, and a 10-bit instance sharing the same serial stream.
module tb_serial_paralelo_n;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data2send, data_out;
  logic       valid_out, active;
  logic [1:0] lock_state;
  logic [9:0] data2send10, data_out10;
  logic       valid_out10, active10;
  logic [1:0] lock_state10;

  int n_checks = 0;
  int n_pass   = 0;
  int vcnt     = 0;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_n dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data2send(data2send), .data_out(data_out), .valid_out(valid_out),
    .active(active), .lock_state(lock_state)
  );

  serial_paralelo_n #(.WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(2), .MISALIGN_MAX(2)) dut10 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data2send(data2send10), .data_out(data_out10), .valid_out(valid_out10),
    .active(active10), .lock_state(lock_state10)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Outputs are sampled 1 time unit after the edge that consumed the bit.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    if (valid_out) vcnt++;
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic pulse_reset;
    reset = 1'b0;
    send_bit(1'b0);
    reset = 1'b1;
  endtask

  initial begin
    // reset state
    reset = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    check("rst_data2send", data2send, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", valid_out, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_state", lock_state, 2'd0);
    reset = 1'b1;

    // acquisition: 3 zero bits, then 5 commas
    vcnt = 0;
    send_word(16'h0, 3);
    send_word(16'hBC, 8);
    check("acq_sync_state", lock_state, 2'd1);
    check("acq_comma_cnt", dut.comma_cnt, 1);
    check("acq_data2send", data2send, 8'hBC);
    send_word(16'hBC, 8);
    send_word(16'hBC, 8);
    send_word(16'h5E, 7);
    check("acq_active_before_last", active, 1'b0);
    send_bit(1'b0);
    check("acq_active_4th", active, 1'b1);
    check("acq_locked_state", lock_state, 2'd2);
    send_word(16'hBC, 8);
    check("acq_no_valid", vcnt, 0);
    check("acq_still_active", active, 1'b1);

    // data delivery
    vcnt = 0;
    send_word(16'h5A, 8);
    check("data1_valid", valid_out, 1'b1);
    check("data1_out", data_out, 8'h5A);
    check("data1_d2s", data2send, 8'h5A);
    send_word(16'h3C, 8);
    check("data2_valid", valid_out, 1'b1);
    check("data2_out", data_out, 8'h3C);
    check("data2_d2s", data2send, 8'h3C);
    send_word(16'hBC, 8);
    check("data_pulses", vcnt, 2);
    check("comma_no_valid", valid_out, 1'b0);
    check("comma_hold_out", data_out, 8'h3C);
    check("comma_d2s", data2send, 8'hBC);

    // phase slip: one extra bit, then two commas seen misaligned
    send_bit(1'b0);
    send_word(16'hBC, 8);
    check("slip1_active", active, 1'b1);
    send_word(16'hBC, 8);
    check("slip2_active", active, 1'b0);
    check("slip2_state", lock_state, 2'd0);
    send_word(16'hBC, 8);
    send_word(16'hBC, 8);
    send_word(16'hBC, 8);
    check("relock3_active", active, 1'b0);
    check("relock3_state", lock_state, 2'd1);
    send_word(16'hBC, 8);
    check("relock4_active", active, 1'b1);
    check("relock4_state", lock_state, 2'd2);

    // reset mid-word while locked
    send_word(16'h5, 3);
    reset = 1'b0;
    send_bit(1'b1);
    check("mrst_data2send", data2send, 8'h00);
    check("mrst_data_out", data_out, 8'h00);
    check("mrst_valid", valid_out, 1'b0);
    check("mrst_active", active, 1'b0);
    check("mrst_state", lock_state, 2'd0);
    reset = 1'b1;
    send_word(16'hBC, 8);
    send_word(16'hBC, 8);
    send_word(16'hBC, 8);
    check("mrst_3commas", active, 1'b0);
    send_word(16'hBC, 8);
    check("mrst_4commas", active, 1'b1);

    // SYNC aborted by a data word
    pulse_reset();
    vcnt = 0;
    send_word(16'hBC, 8);
    send_word(16'hBC, 8);
    check("abort_sync", lock_state, 2'd1);
    check("abort_cnt2", dut.comma_cnt, 2);
    send_word(16'h11, 8);
    check("abort_state", lock_state, 2'd0);
    check("abort_cnt0", dut.comma_cnt, 0);
    check("abort_active", active, 1'b0);
    check("abort_out_hold", data_out, 8'h00);
    check("abort_d2s", data2send, 8'h11);
    check("abort_no_valid", vcnt, 0);

    // 10-bit instance
    pulse_reset();
    send_word(16'h0, 3);
    send_word(16'h17C, 10);
    check("w10_sync", lock_state10, 2'd1);
    check("w10_active1", active10, 1'b0);
    send_word(16'h17C, 10);
    check("w10_active2", active10, 1'b1);
    check("w10_locked", lock_state10, 2'd2);
    send_word(16'h2A5, 10);
    check("w10_valid", valid_out10, 1'b1);
    check("w10_data", data_out10, 10'h2A5);
    send_word(16'h17C, 10);
    check("w10_hold", data_out10, 10'h2A5);
    check("w10_no_valid", valid_out10, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
